memory_arbiter: RTL and testbench

//  Parametrised N-port shared-memory controller. Replaces the state-select memory mux.

---
 rtl/memory_arbiter_pkg.sv | 15 +
 rtl/memory_arbiter_rr_arbiter.sv | 65 ++++++
 rtl/memory_arbiter.sv | 108 ++++++++++
 tb/tb_memory_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared constants and helpers for the N-port shared-memory arbiter.
// Arbitration mode encodings and the supported port-count range live here.
package memory_arbiter_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;
  localparam int MIN_PORTS  = 2;
  localparam int MAX_PORTS  = 8;

  // Modulo-n increment of a port index, used for the round-robin pointer.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_arbiter.sv
// Single-grant arbiter over an eligibility mask: round-robin from an internal
// pointer (MODE_RR) or lowest index first (MODE_FIXED).
module memory_arbiter_rr_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = MODE_RR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         eligible,
  output logic [N-1:0]         onehot_win,
  output logic [$clog2(N)-1:0] win_idx,
  output logic                 any
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_cand;
  logic [N-1:0]     w_onehot;
  logic             w_any;

  // Scan N candidates starting at the pointer (or at 0 in fixed mode);
  // the first eligible one wins.
  // NOTE: every output of this always_comb gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_idx    = '0;
    w_cand   = '0;
    w_any    = 1'b0;
    w_onehot = '0;
    for (int k = 0; k < N; k++) begin
      if (MODE == MODE_FIXED) begin
        w_cand = IDX_W'(k);
      end else begin
        w_cand = IDX_W'((int'(r_ptr) + k) % N);
      end
      if (!w_any && eligible[w_cand]) begin
        w_any = 1'b1;
        w_idx = w_cand;
      end
    end
    if (w_any) begin
      w_onehot[w_idx] = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (en && w_any && (MODE == MODE_RR)) begin
      r_ptr <= IDX_W'(wrap_inc(int'(w_idx), N));
    end
  end

  assign onehot_win = w_onehot;
  assign win_idx    = w_idx;
  assign any        = w_any;

endmodule

// File: rtl/memory_arbiter.sv
// N-port shared-memory controller: one arbitrated access per clock to a
// single-port synchronous RAM, with per-port qualified read return.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 7,
  parameter int DEPTH     = 128,
  parameter int MODE      = MODE_RR
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        rerr
);

  localparam int IDX_W  = $clog2(NUM_PORTS);
  localparam int MEM_AW = $clog2(DEPTH);

  logic [NUM_PORTS-1:0] r_gnt;
  logic [NUM_PORTS-1:0] r_rvalid;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_rerr;
  logic [DATA_W-1:0]    r_mem [DEPTH];

  logic [NUM_PORTS-1:0] w_eligible;
  logic [NUM_PORTS-1:0] w_onehot;
  logic [IDX_W-1:0]     w_win_idx;
  logic                 w_any;
  logic [ADDR_W-1:0]    w_addr;
  logic [DATA_W-1:0]    w_wdata;
  logic                 w_we;
  logic                 w_in_range;
  logic [MEM_AW-1:0]    w_mem_idx;
  logic [DATA_W-1:0]    w_rd_word;
  logic                 w_do_read;
  logic                 w_do_write;

  // A port whose grant is showing this cycle is masked, so a client still
  // holding req while it observes gnt is never serviced twice.
  assign w_eligible = req & ~r_gnt;

  memory_arbiter_rr_arbiter #(
    .N    (NUM_PORTS),
    .MODE (MODE)
  ) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .eligible   (w_eligible),
    .onehot_win (w_onehot),
    .win_idx    (w_win_idx),
    .any        (w_any)
  );

  assign w_addr     = addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
  assign w_wdata    = wdata[int'(w_win_idx)*DATA_W +: DATA_W];
  assign w_we       = we[w_win_idx];
  assign w_in_range = (int'(w_addr) < DEPTH);
  assign w_mem_idx  = MEM_AW'(w_addr);
  assign w_rd_word  = w_in_range ? r_mem[w_mem_idx] : '0;
  assign w_do_read  = en && w_any && !w_we;
  assign w_do_write = en && w_any && w_we && w_in_range;

  // NOTE: the RAM array has no reset; contents are undefined after power-up
  // and survive rst_n, which keeps it mappable onto a block RAM.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[w_mem_idx] <= w_wdata;
    end
  end

  // Response registers: grant, read qualifier and range error are valid for
  // exactly the cycle after the access; rdata holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_rerr   <= 1'b0;
    end else if (!en) begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_rerr   <= 1'b0;
    end else begin
      r_gnt    <= w_onehot;
      r_rerr   <= w_any && !w_in_range;
      r_rvalid <= w_do_read ? w_onehot : '0;
      if (w_do_read) begin
        r_rdata <= w_rd_word;
      end
    end
  end

  assign gnt    = r_gnt;
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
  assign rerr   = r_rerr;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a round-robin and a fixed-priority instance
// (DEPTH=100) against a behavioural model, directed steps then random traffic.
module tb_memory_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int AW    = 7;
  localparam int DEPTH = 100;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  // Index 0: MODE=0 (round-robin), index 1: MODE=1 (fixed priority).
  logic [N-1:0]    req    [2];
  logic [N-1:0]    we     [2];
  logic [N*AW-1:0] addr   [2];
  logic [N*DW-1:0] wdata  [2];
  logic [N-1:0]    gnt    [2];
  logic [N-1:0]    rvalid [2];
  logic [DW-1:0]   rdata  [2];
  logic            rerr   [2];

  // Reference model state, expressed as the spec's observable behaviour.
  int            m_ptr   [2];
  logic [N-1:0]  m_gnt   [2];
  logic [N-1:0]  m_rvalid[2];
  logic [DW-1:0] m_rdata [2];
  logic          m_rerr  [2];
  bit            m_rdata_known [2];
  logic [DW-1:0] m_mem   [2][128];
  bit            m_known [2][128];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.NUM_PORTS(N), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .gnt(gnt[0]), .rvalid(rvalid[0]), .rdata(rdata[0]), .rerr(rerr[0])
  );

  memory_arbiter #(.NUM_PORTS(N), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .gnt(gnt[1]), .rvalid(rvalid[1]), .rdata(rdata[1]), .rerr(rerr[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_ptr[s] = 0; m_gnt[s] = '0; m_rvalid[s] = '0;
      m_rdata[s] = '0; m_rerr[s] = 1'b0; m_rdata_known[s] = 1'b1;
    end
  endtask

  // Predict the state after the coming rising edge from the current inputs.
  task automatic model_edge(input int s);
    logic [N-1:0] elig;
    int w;
    int idx;
    int a;
    elig = req[s] & ~m_gnt[s];
    m_gnt[s] = '0; m_rvalid[s] = '0; m_rerr[s] = 1'b0;
    if (!en) return;
    w = -1;
    for (int k = 0; k < N; k++) begin
      idx = (s == 0) ? (m_ptr[s] + k) % N : k;
      if (w < 0 && elig[idx]) w = idx;
    end
    if (w < 0) return;
    m_gnt[s][w] = 1'b1;
    if (s == 0) m_ptr[s] = (w + 1) % N;
    a = int'(addr[s][w*AW +: AW]);
    m_rerr[s] = (a >= DEPTH);
    if (we[s][w]) begin
      if (a < DEPTH) begin
        m_mem[s][a] = wdata[s][w*DW +: DW];
        m_known[s][a] = 1'b1;
      end
    end else begin
      m_rvalid[s][w] = 1'b1;
      if (a < DEPTH) begin
        m_rdata[s] = m_mem[s][a];
        m_rdata_known[s] = m_known[s][a];
      end else begin
        m_rdata[s] = '0;
        m_rdata_known[s] = 1'b1;
      end
    end
  endtask

  // One clock: predict, advance, then compare both instances on the falling edge.
  task automatic step();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("gnt[%0d]", s), 32'(gnt[s]), 32'(m_gnt[s]));
      check($sformatf("rvalid[%0d]", s), 32'(rvalid[s]), 32'(m_rvalid[s]));
      check($sformatf("rerr[%0d]", s), 32'(rerr[s]), 32'(m_rerr[s]));
      if (m_rdata_known[s]) check($sformatf("rdata[%0d]", s), 32'(rdata[s]), 32'(m_rdata[s]));
    end
  endtask

  task automatic set_port(input int s, input int i, input logic r, input logic w,
                          input int a, input logic [DW-1:0] d);
    req[s][i] = r;
    we[s][i] = w;
    addr[s][i*AW +: AW] = AW'(a);
    wdata[s][i*DW +: DW] = d;
  endtask

  // Clients may only change a port that is idle or was just granted.
  task automatic rand_clients(input int s);
    int a;
    for (int i = 0; i < N; i++) begin
      if (!req[s][i] || m_gnt[s][i]) begin
        a = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH, 127) : $urandom_range(0, 15);
        if ($urandom_range(0, 3) != 0)
          set_port(s, i, 1'b1, 1'($urandom_range(0, 1)), a, DW'($urandom));
        else
          req[s][i] = 1'b0;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("%s_gnt%0d", tag, s), 32'(gnt[s]), 32'h0);
      check($sformatf("%s_rvalid%0d", tag, s), 32'(rvalid[s]), 32'h0);
      check($sformatf("%s_rdata%0d", tag, s), 32'(rdata[s]), 32'h0);
      check($sformatf("%s_rerr%0d", tag, s), 32'(rerr[s]), 32'h0);
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      req[s] = '0; we[s] = '0; addr[s] = '0; wdata[s] = '0;
      for (int a = 0; a < 128; a++) begin
        m_mem[s][a] = '0; m_known[s][a] = 1'b0;
      end
    end
    en = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Traffic so outputs are non-zero, then an asynchronous mid-cycle reset.
    for (int c = 0; c < 20; c++) begin
      rand_clients(0); rand_clients(1);
      step();
    end
    for (int i = 0; i < N; i++) begin
      set_port(0, i, 1'b1, 1'b0, i, 8'h00);
      set_port(1, i, 1'b1, 1'b0, i, 8'h00);
    end
    step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_rst");
    #1 rst_n = 1'b1;
    step();

    // Port 0 writes 0x0A to addr 10, then port 1 reads it back.
    req[0] = '0;
    step(); step();
    set_port(0, 0, 1'b1, 1'b1, 10, 8'h0A);
    step();
    check("wr_gnt0", 32'(gnt[0]), 32'b0001);
    check("wr_rvalid0", 32'(rvalid[0]), 32'h0);
    req[0] = '0;
    set_port(0, 1, 1'b1, 1'b0, 10, 8'h00);
    step();
    check("rd_gnt1", 32'(gnt[0]), 32'b0010);
    check("rd_rvalid1", 32'(rvalid[0]), 32'b0010);
    check("rd_data", 32'(rdata[0]), 32'h0A);

    // All four ports read continuously: pointer is 2 after port 1's grant.
    for (int i = 0; i < N; i++) set_port(0, i, 1'b1, 1'b0, 10, 8'h00);
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("rr_order%0d", k), 32'(gnt[0]), 32'(1 << ((2 + k) % N)));
      check($sformatf("rr_data%0d", k), 32'(rdata[0]), 32'h0A);
    end

    // Fixed priority with 1110 held: grants alternate 1,2 and port 3 starves.
    req[1] = '0;
    step(); step();
    for (int i = 1; i < N; i++) set_port(1, i, 1'b1, 1'b0, 5, 8'h00);
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("fp_alt%0d", k), 32'(gnt[1]), (k % 2 == 0) ? 32'b0010 : 32'b0100);
    end
    req[1] = '0;

    // Out-of-range accesses against DEPTH=100.
    req[0] = '0;
    step();
    set_port(0, 2, 1'b1, 1'b0, 120, 8'h00);
    step();
    check("oor_rd_rvalid", 32'(rvalid[0]), 32'b0100);
    check("oor_rd_data", 32'(rdata[0]), 32'h0);
    check("oor_rd_rerr", 32'(rerr[0]), 32'h1);
    req[0] = '0;
    step();
    set_port(0, 3, 1'b1, 1'b1, 120, 8'hFF);
    step();
    check("oor_wr_gnt", 32'(gnt[0]), 32'b1000);
    check("oor_wr_rerr", 32'(rerr[0]), 32'h1);
    check("oor_wr_rvalid", 32'(rvalid[0]), 32'h0);
    req[0] = '0;
    set_port(0, 0, 1'b1, 1'b0, 10, 8'h00);
    step();
    check("after_oor_data", 32'(rdata[0]), 32'h0A);
    check("after_oor_rerr", 32'(rerr[0]), 32'h0);
    req[0] = '0;
    step();
    set_port(0, 0, 1'b1, 1'b0, 120, 8'h00);
    step();
    check("oor_rd2_data", 32'(rdata[0]), 32'h0);

    // Clock enable low for three cycles with all ports pending.
    req[0] = '0;
    for (int i = 0; i < N; i++) set_port(0, i, 1'b1, 1'b0, 10, 8'h00);
    step();
    check("pre_en_gnt", 32'(gnt[0]), 32'b0010);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("en0_gnt%0d", k), 32'(gnt[0]), 32'h0);
      check($sformatf("en0_rvalid%0d", k), 32'(rvalid[0]), 32'h0);
      check($sformatf("en0_rdata%0d", k), 32'(rdata[0]), 32'h0A);
    end
    en = 1'b1;
    step();
    check("en_resume", 32'(gnt[0]), 32'b0100);

    // Random traffic on both instances with occasional enable drops.
    for (int c = 0; c < 600; c++) begin
      rand_clients(0); rand_clients(1);
      en = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
